// File: rtl/dist_sq_issue.sv
// dist_sq_issue: squared-magnitude feeder for the fixed-point square-root unit.
// Takes a signed 3-D offset, accumulates dx^2+dy^2+dz^2 over three cycles on one
// shared multiplier, clamps the sum into the root's unsigned A format, then runs
// the start/busy handshake with the root and pulses done when the result is ready.
//
// Handshakes:
//   Input side  : a transfer happens on a rising clk edge where in_valid & in_ready.
//                 in_ready is high only in IDLE; in_valid outside IDLE is ignored.
//   Root side   : start is raised in ISSUE and held until sqrt_busy=1 is sampled;
//                 completion is taken as the first sampled sqrt_busy=0 after that.
//                 sqrt_busy is ignored in every other state.
module dist_sq_issue #(
   parameter int IN_B    = 7,
   parameter int IN_FP_B = 2,
   parameter int A_INT_B = 8,
   parameter int A_FP_B  = 4
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [IN_B-1:0]     dx,
   input  logic signed [IN_B-1:0]     dy,
   input  logic signed [IN_B-1:0]     dz,
   output logic [A_INT_B+A_FP_B-1:0]  A,
   output logic                       start,
   input  logic                       sqrt_busy,
   output logic                       sat,
   output logic                       zero,
   output logic                       done,
   output logic [2:0]                 o_dbg_state
);

   localparam int A_W    = A_INT_B + A_FP_B;
   localparam int PROD_W = 2 * IN_B;
   localparam int ACC_W  = 2 * IN_B + 2;

   // Largest value A can carry; sums above it are clamped.
   localparam logic [ACC_W-1:0] A_MAX = ACC_W'({A_W{1'b1}});

   // The sum of squares carries 2*IN_FP_B fraction bits, so A must match that
   // scaling for A=sum[A_W-1:0] to be a plain bit copy.
   if (A_FP_B != 2 * IN_FP_B) begin : g_fp_check
      $error("dist_sq_issue: A_FP_B must equal 2*IN_FP_B");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MUL_X = 3'd1,
      S_MUL_Y = 3'd2,
      S_MUL_Z = 3'd3,
      S_CLAMP = 3'd4,
      S_ISSUE = 3'd5,
      S_WAIT  = 3'd6,
      S_FIN   = 3'd7
   } state_t;

   state_t                   r_state;
   logic signed [IN_B-1:0]   r_dx;
   logic signed [IN_B-1:0]   r_dy;
   logic signed [IN_B-1:0]   r_dz;
   logic [ACC_W-1:0]         r_acc;
   logic [A_W-1:0]           r_a;
   logic                     r_start;
   logic                     r_sat;
   logic                     r_zero;
   logic                     r_done;
   logic                     r_in_ready;

   logic signed [IN_B-1:0]   w_op;
   logic signed [PROD_W-1:0] w_prod_s;
   logic [PROD_W-1:0]        w_prod;
   logic [ACC_W-1:0]         w_prod_ext;
   logic                     w_accept;

   assign w_accept = in_valid & r_in_ready;

   // Shared multiplier operand: the component being squared this cycle.
   always_comb begin
      w_op = r_dz;
      case (r_state)
         S_MUL_X: w_op = r_dx;
         S_MUL_Y: w_op = r_dy;
         default: w_op = r_dz;
      endcase
   end

   // Signed square in 2*IN_B bits; never negative, and (-2^(IN_B-1))^2 = 2^(2*IN_B-2)
   // still fits, so the unsigned reinterpretation is exact.
   assign w_prod_s   = w_op * w_op;
   assign w_prod     = $unsigned(w_prod_s);
   assign w_prod_ext = ACC_W'(w_prod);

   // Control FSM with every output registered; reset aborts any operation at once.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state    <= S_IDLE;
         r_dx       <= '0;
         r_dy       <= '0;
         r_dz       <= '0;
         r_acc      <= '0;
         r_a        <= '0;
         r_start    <= 1'b0;
         r_sat      <= 1'b0;
         r_zero     <= 1'b0;
         r_done     <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dx       <= dx;
                  r_dy       <= dy;
                  r_dz       <= dz;
                  r_acc      <= '0;
                  r_sat      <= 1'b0;
                  r_zero     <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_MUL_X;
               end
            end
            S_MUL_X: begin
               r_acc   <= w_prod_ext;
               r_state <= S_MUL_Y;
            end
            S_MUL_Y: begin
               r_acc   <= r_acc + w_prod_ext;
               r_state <= S_MUL_Z;
            end
            S_MUL_Z: begin
               r_acc   <= r_acc + w_prod_ext;
               r_state <= S_CLAMP;
            end
            S_CLAMP: begin
               if (r_acc > A_MAX) begin
                  r_a   <= '1;
                  r_sat <= 1'b1;
               end else begin
                  r_a   <= r_acc[A_W-1:0];
                  r_sat <= 1'b0;
               end
               r_zero <= (r_acc == '0);
               // The root cannot normalise zero, so that case skips the handshake.
               if (r_acc == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  r_start <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Hold start until the root acknowledges with busy.
               if (sqrt_busy) begin
                  r_start <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!sqrt_busy) begin
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end
            end
            S_FIN: begin
               r_done     <= 1'b0;
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: begin
               r_start    <= 1'b0;
               r_done     <= 1'b0;
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign A           = r_a;
   assign start       = r_start;
   assign sat         = r_sat;
   assign zero        = r_zero;
   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule
